// File: rtl/dff_vector_checker.sv
// Vector-driven checker for a discrete D flip-flop: applies set/clr/din, pulses dut_clk, compares dut_q.
// Define DFF_CHK_SYNC_EN to route dut_q through a 2-flop synchronizer (adds two cycles before compare).
module dff_vector_checker #(
  parameter int NVEC   = 16,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 8,
  parameter int IDX_W  = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic             vec_set,
  input  logic             vec_clr,
  input  logic             vec_din,
  input  logic             vec_exp,
  output logic             dut_set,
  output logic             dut_clr,
  output logic             dut_din,
  output logic             dut_clk,
  input  logic             dut_q,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [IDX_W-1:0] fail_idx
);

  // state    | meaning
  // IDLE     | after reset, waiting for start
  // WAIT_VEC | vec_ready high, waiting for a vector
  // APPLY    | captured vector driven onto DUT pins
  // PULSE    | dut_clk register loaded high
  // SETTLE   | DUT output settling (plus synchronizer delay)
  // CHECK    | compare sampled dut_q, update results
  // DONE     | run complete, results held
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_VEC, S_APPLY, S_PULSE, S_SETTLE, S_CHECK, S_DONE
  } state_t;

  logic q_smp;

`ifdef DFF_CHK_SYNC_EN
  localparam int SETTLE_TOT = SETTLE + 2;
  logic [1:0] sync_q, sync_d;
  assign sync_d = {sync_q[0], dut_q};
  always_ff @(posedge clk or posedge clr) begin
    if (clr) sync_q <= '0;
    else     sync_q <= sync_d;
  end
  assign q_smp = sync_q[1];
`else
  localparam int SETTLE_TOT = SETTLE;
  assign q_smp = dut_q;
`endif

  localparam int SCNT_W = $clog2(SETTLE_TOT) + 1;

  state_t             state_q, state_d;
  logic [SCNT_W-1:0]  scnt_q, scnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               cap_set_q, cap_set_d, cap_clr_q, cap_clr_d;
  logic               cap_din_q, cap_din_d, cap_exp_q, cap_exp_d;
  logic               dut_set_q, dut_set_d, dut_clr_q, dut_clr_d;
  logic               dut_din_q, dut_din_d, dut_clk_q, dut_clk_d;
  logic               vec_ready_q, vec_ready_d, busy_q, busy_d, done_q, done_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
  logic [IDX_W-1:0]   fail_idx_q, fail_idx_d;

  always_comb begin
    state_d    = state_q;
    scnt_d     = scnt_q;
    idx_d      = idx_q;
    cap_set_d  = cap_set_q;
    cap_clr_d  = cap_clr_q;
    cap_din_d  = cap_din_q;
    cap_exp_d  = cap_exp_q;
    dut_set_d  = dut_set_q;
    dut_clr_d  = dut_clr_q;
    dut_din_d  = dut_din_q;
    dut_clk_d  = 1'b0;
    err_d      = err_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    fail_idx_d = fail_idx_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          pass_cnt_d = '0;
          fail_cnt_d = '0;
          fail_idx_d = '0;
          err_d      = 1'b0;
          idx_d      = '0;
          state_d    = S_WAIT_VEC;
        end
      end
      S_WAIT_VEC: begin
        if (vec_valid && vec_ready_q) begin
          cap_set_d = vec_set;
          cap_clr_d = vec_clr;
          cap_din_d = vec_din;
          cap_exp_d = vec_exp;
          state_d   = S_APPLY;
        end
      end
      S_APPLY: begin
        dut_set_d = cap_set_q;
        dut_clr_d = cap_clr_q;
        dut_din_d = cap_din_q;
        state_d   = S_PULSE;
      end
      S_PULSE: begin
        dut_clk_d = 1'b1;
        scnt_d    = SCNT_W'(SETTLE_TOT - 1);
        state_d   = S_SETTLE;
      end
      S_SETTLE: begin
        if (scnt_q == '0) state_d = S_CHECK;
        else              scnt_d  = scnt_q - SCNT_W'(1);
      end
      S_CHECK: begin
        if (q_smp == cap_exp_q) begin
          if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + CNT_W'(1);
        end else begin
          if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_W'(1);
          if (!err_q) fail_idx_d = idx_q;
          err_d = 1'b1;
        end
        idx_d   = idx_q + IDX_W'(1);
        state_d = (idx_q == IDX_W'(NVEC - 1)) ? S_DONE : S_WAIT_VEC;
      end
      default: state_d = S_IDLE;
    endcase
    // Status outputs are registered from the next state so they line up with it.
    vec_ready_d = (state_d == S_WAIT_VEC);
    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= S_IDLE;
      scnt_q      <= '0;
      idx_q       <= '0;
      cap_set_q   <= 1'b0;
      cap_clr_q   <= 1'b0;
      cap_din_q   <= 1'b0;
      cap_exp_q   <= 1'b0;
      dut_set_q   <= 1'b0;
      dut_clr_q   <= 1'b0;
      dut_din_q   <= 1'b0;
      dut_clk_q   <= 1'b0;
      vec_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      fail_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      scnt_q      <= scnt_d;
      idx_q       <= idx_d;
      cap_set_q   <= cap_set_d;
      cap_clr_q   <= cap_clr_d;
      cap_din_q   <= cap_din_d;
      cap_exp_q   <= cap_exp_d;
      dut_set_q   <= dut_set_d;
      dut_clr_q   <= dut_clr_d;
      dut_din_q   <= dut_din_d;
      dut_clk_q   <= dut_clk_d;
      vec_ready_q <= vec_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      fail_idx_q  <= fail_idx_d;
    end
  end

  assign vec_ready = vec_ready_q;
  assign dut_set   = dut_set_q;
  assign dut_clr   = dut_clr_q;
  assign dut_din   = dut_din_q;
  assign dut_clk   = dut_clk_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign pass_cnt  = pass_cnt_q;
  assign fail_cnt  = fail_cnt_q;
  assign fail_idx  = fail_idx_q;

endmodule
